// File: rtl/tof_pkg.sv
// Shared constants and types for the ToF frame collector.
package tof_pkg;

  localparam int DEF_N_SENSORS = 8;
  localparam int DEF_N_ZONES   = 64;
  localparam int DEF_DATA_W    = 16;

  localparam int MODE_DROP = 0;
  localparam int MODE_HOLD = 1;

  typedef logic [1:0] state_t;

  localparam state_t S_COLLECT = 2'd0;
  localparam state_t S_COMMIT  = 2'd1;
  localparam state_t S_HOLD    = 2'd2;

  // 8-bit counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/tof_pingpong_ram.sv
// Two-bank simple dual-port RAM: one write port, one registered read port.
// Bank select is the top address bit so the array maps onto a single BRAM.
module tof_pingpong_ram #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int SLOTS = 2 ** (AW + 1);

  logic [DATA_W-1:0] mem [0:SLOTS-1];

  // Write port into the selected bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // Registered read port (no reset so it stays BRAM-friendly).
  always_ff @(posedge clk) begin
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/tof_frame_collector.sv
// Collects one distance word per (sensor, zone) into a write bank, then
// publishes the completed frame by swapping ping-pong banks.
module tof_frame_collector
  import tof_pkg::*;
#(
  parameter int N_SENSORS = DEF_N_SENSORS,
  parameter int N_ZONES   = DEF_N_ZONES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MODE      = MODE_DROP,
  // Index fields carry one extra bit so out-of-range indices are representable.
  parameter int SENS_W    = $clog2(N_SENSORS) + 1,
  parameter int ZONE_W    = $clog2(N_ZONES) + 1,
  parameter int ADDR_W    = $clog2(N_SENSORS * N_ZONES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SENS_W-1:0] in_sensor,
  input  logic [ZONE_W-1:0] in_zone,
  input  logic [DATA_W-1:0] in_data,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic [7:0]        frame_id,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        overflow_cnt
);

  localparam int TOTAL = N_SENSORS * N_ZONES;
  localparam int CNT_W = $clog2(TOTAL + 1);

  state_t            state;
  state_t            state_next;
  logic [TOTAL-1:0]  bitmap;
  logic [CNT_W-1:0]  filled;
  logic              wr_bank;
  logic              in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              new_pos;
  logic              fill_last;
  logic              do_commit;
  logic              do_drop;

  assign in_range  = (32'(in_sensor) < N_SENSORS) && (32'(in_zone) < N_ZONES);
  assign wr_addr   = ADDR_W'(in_sensor) * ADDR_W'(N_ZONES) + ADDR_W'(in_zone);
  assign wr_en     = in_valid && in_ready && (state == S_COLLECT) && in_range;
  // Duplicates rewrite data but never advance completion.
  assign new_pos   = wr_en && !bitmap[wr_addr];
  assign fill_last = new_pos && (filled == CNT_W'(TOTAL - 1));

  // Next-state and commit/drop decisions.
  always_comb begin
    state_next = state;
    do_commit  = 1'b0;
    do_drop    = 1'b0;
    case (state)
      S_COLLECT: begin
        if (fill_last) begin
          state_next = S_COMMIT;
        end else begin
          state_next = S_COLLECT;
        end
      end
      S_COMMIT: begin
        if (!frame_ready || frame_ack) begin
          do_commit  = 1'b1;
          state_next = S_COLLECT;
        end else if (MODE == MODE_HOLD) begin
          state_next = S_HOLD;
        end else begin
          do_drop    = 1'b1;
          state_next = S_COLLECT;
        end
      end
      S_HOLD: begin
        // frame_ready is necessarily 1 here, so an ack releases the old frame.
        if (frame_ack) begin
          do_commit  = 1'b1;
          state_next = S_COLLECT;
        end else begin
          state_next = S_HOLD;
        end
      end
      default: begin
        state_next = S_COLLECT;
      end
    endcase
  end

  // FSM state and registered in_ready (held low through reset).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_COLLECT;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == S_COLLECT);
    end
  end

  // Received-position bitmap and unique-position count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitmap <= '0;
      filled <= '0;
    end else if (state == S_COMMIT) begin
      bitmap <= '0;
      filled <= '0;
    end else if (new_pos) begin
      bitmap[wr_addr] <= 1'b1;
      filled          <= filled + CNT_W'(1);
    end
  end

  // Bank select, frame handshake and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank      <= 1'b0;
      frame_ready  <= 1'b0;
      frame_id     <= 8'd0;
      overflow_cnt <= 8'd0;
    end else begin
      if (do_commit) begin
        wr_bank     <= ~wr_bank;
        frame_ready <= 1'b1;
        frame_id    <= frame_id + 8'd1;
      end else if (frame_ack && frame_ready) begin
        frame_ready <= 1'b0;
      end
      if (do_drop) begin
        overflow_cnt <= sat_inc8(overflow_cnt);
      end
    end
  end

  tof_pingpong_ram #(
    .DEPTH  (TOTAL),
    .DATA_W (DATA_W),
    .AW     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_bank (~wr_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_tof_frame_collector.sv
// Directed bench for tof_frame_collector: one DROP-mode and one HOLD-mode instance.
module tb_tof_frame_collector;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        sel;
  logic        ack;
  logic [3:0]  in_sensor;
  logic [6:0]  in_zone;
  logic [15:0] in_data;
  logic [8:0]  rd_addr;

  logic        v0, v1, a0, a1;
  logic        ir0, ir1, fr0, fr1;
  logic [7:0]  id0, id1, ov0, ov1;
  logic [15:0] rd0, rd1;
  logic        cur_ir;

  int checks = 0;
  int errors = 0;

  assign v0 = in_valid & ~sel;
  assign v1 = in_valid & sel;
  assign a0 = ack & ~sel;
  assign a1 = ack & sel;
  assign cur_ir = sel ? ir1 : ir0;

  tof_frame_collector #(.N_SENSORS(8), .N_ZONES(64), .DATA_W(16), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(ir0),
    .in_sensor(in_sensor), .in_zone(in_zone), .in_data(in_data),
    .frame_ready(fr0), .frame_ack(a0), .frame_id(id0),
    .rd_addr(rd_addr), .rd_data(rd0), .overflow_cnt(ov0)
  );

  tof_frame_collector #(.N_SENSORS(8), .N_ZONES(64), .DATA_W(16), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(ir1),
    .in_sensor(in_sensor), .in_zone(in_zone), .in_data(in_data),
    .frame_ready(fr1), .frame_ack(a1), .frame_id(id1),
    .rd_addr(rd_addr), .rd_data(rd1), .overflow_cnt(ov1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word and hold it until accepted (bounded wait).
  task automatic send(input int s, input int z, input int d);
    int n;
    in_sensor = 4'(s);
    in_zone   = 7'(z);
    in_data   = 16'(d);
    in_valid  = 1'b1;
    n = 0;
    while (cur_ir !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout observed=%0d expected=1", cur_ir);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Send permuted positions i_lo..i_hi with data = base + addr (addr 202 -> 0x2222 when dup).
  task automatic frame_part(input int i_lo, input int i_hi, input int base, input bit dup);
    int a;
    int d;
    for (int i = i_lo; i <= i_hi; i++) begin
      a = (i * 37 + 5) % 512;
      d = (dup && a == 202) ? 32'h2222 : base + a;
      send(a / 64, a % 64, d);
    end
  endtask

  task automatic read_chk(input string tag, input int addr, input int exp, input bit which);
    rd_addr = 9'(addr);
    step();
    chk(tag, which ? 32'(rd1) : 32'(rd0), 32'(exp));
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; in_valid = 1'b0; sel = 1'b0; ack = 1'b0;
    in_sensor = 4'd0; in_zone = 7'd0; in_data = 16'd0; rd_addr = 9'd0;

    // Reset values
    repeat (3) step();
    chk("rst_in_ready", 32'(ir0), 32'd0);
    chk("rst_frame_ready", 32'(fr0), 32'd0);
    chk("rst_frame_id", 32'(id0), 32'd0);
    chk("rst_overflow", 32'(ov0), 32'd0);
    chk("rst_in_ready_m1", 32'(ir1), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(ir0), 32'd1);
    chk("post_rst_in_ready_m1", 32'(ir1), 32'd1);

    // Frame 1: data = addr, shuffled order
    frame_part(0, 510, 0, 1'b0);
    chk("f1_no_early_ready", 32'(fr0), 32'd0);
    frame_part(511, 511, 0, 1'b0);
    chk("f1_commit_cycle_ready", 32'(fr0), 32'd0);
    chk("f1_commit_cycle_in_ready", 32'(ir0), 32'd0);
    step();
    chk("f1_frame_ready", 32'(fr0), 32'd1);
    chk("f1_frame_id", 32'(id0), 32'd1);
    chk("f1_in_ready", 32'(ir0), 32'd1);
    read_chk("f1_rd300", 300, 300, 1'b0);

    // DROP mode: second frame without ack is discarded
    frame_part(0, 511, 32'h1000, 1'b0);
    step();
    chk("drop_overflow", 32'(ov0), 32'd1);
    chk("drop_frame_id", 32'(id0), 32'd1);
    chk("drop_frame_ready", 32'(fr0), 32'd1);
    chk("drop_in_ready", 32'(ir0), 32'd1);
    read_chk("drop_rd0", 0, 0, 1'b0);
    read_chk("drop_rd300", 300, 300, 1'b0);

    // Ack clears frame_ready; a stray ack while not ready is ignored
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_clears_ready", 32'(fr0), 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("idle_ack_ready", 32'(fr0), 32'd0);
    chk("idle_ack_id", 32'(id0), 32'd1);

    // Duplicate (3,10) plus out-of-range words
    send(8, 0, 32'hDEAD);
    send(0, 64, 32'hBEEF);
    send(3, 10, 32'h1111);
    frame_part(0, 510, 32'h2000, 1'b1);
    send(15, 63, 32'hDEAD);
    send(7, 127, 32'hBEEF);
    send(8, 0, 32'hCAFE);
    chk("dup_no_early_ready", 32'(fr0), 32'd0);
    chk("dup_still_collect", 32'(ir0), 32'd1);
    frame_part(511, 511, 32'h2000, 1'b1);
    step();
    chk("dup_frame_ready", 32'(fr0), 32'd1);
    chk("dup_frame_id", 32'(id0), 32'd2);
    read_chk("dup_rd202", 202, 32'h2222, 1'b0);
    read_chk("oor_rd0", 0, 32'h2000, 1'b0);
    read_chk("oor_rd64", 64, 32'h2040, 1'b0);
    read_chk("oor_rd63", 63, 32'h203F, 1'b0);
    read_chk("oor_rd511", 511, 32'h21FF, 1'b0);
    read_chk("dup_rd480", 480, 32'h21E0, 1'b0);
    ack = 1'b1; step(); ack = 1'b0;

    // Reset after 200 words, then a fresh frame
    frame_part(0, 199, 32'h3000, 1'b0);
    reset = 1'b1;
    step(); step();
    chk("mid_rst_in_ready", 32'(ir0), 32'd0);
    chk("mid_rst_frame_ready", 32'(fr0), 32'd0);
    chk("mid_rst_frame_id", 32'(id0), 32'd0);
    chk("mid_rst_overflow", 32'(ov0), 32'd0);
    reset = 1'b0;
    step();
    chk("mid_rst_release_ready", 32'(ir0), 32'd1);
    frame_part(0, 510, 32'h4000, 1'b0);
    chk("fresh_no_early_ready", 32'(fr0), 32'd0);
    frame_part(511, 511, 32'h4000, 1'b0);
    chk("fresh_commit_cycle_ready", 32'(fr0), 32'd0);
    step();
    chk("fresh_frame_ready", 32'(fr0), 32'd1);
    chk("fresh_frame_id", 32'(id0), 32'd1);
    read_chk("fresh_rd300", 300, 32'h412C, 1'b0);

    // HOLD mode instance
    sel = 1'b1;
    frame_part(0, 511, 32'h5000, 1'b0);
    step();
    chk("hold_f1_ready", 32'(fr1), 32'd1);
    chk("hold_f1_id", 32'(id1), 32'd1);
    frame_part(0, 511, 32'h6000, 1'b0);
    chk("hold_commit_in_ready", 32'(ir1), 32'd0);
    step();
    chk("hold_in_ready", 32'(ir1), 32'd0);
    chk("hold_frame_ready", 32'(fr1), 32'd1);
    chk("hold_frame_id", 32'(id1), 32'd1);
    step(); step();
    chk("hold_still_stalled", 32'(ir1), 32'd0);
    chk("hold_no_overflow", 32'(ov1), 32'd0);
    read_chk("hold_rd0_old", 0, 32'h5000, 1'b1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("hold_ack_id", 32'(id1), 32'd2);
    chk("hold_ack_ready", 32'(fr1), 32'd1);
    chk("hold_ack_in_ready", 32'(ir1), 32'd1);
    read_chk("hold_rd0_new", 0, 32'h6000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
